mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that owns the 2-bit `Selector` of the 4:1 word multiplexer on the shared datapath. Four sources raise requests; the arbiter grants one source at a time and holds `Selector` stable for a burst of `BURST_LENGTH` transfers to a downstream valid/ready consumer. It then rotates priority so that no source starves.

## Interface
- `BURST_LENGTH`, 1, transfers per grant before rotation; legal range 1..256.
- `COUNT_WIDTH`, derived as `max(1, clog2(BURST_LENGTH))`, width of the beat counter. Local only, not overridable.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Request`  in  4  per-source request; bit i is held high while source i has data at mux input i.
- `Ready`  in  1  downstream accepts the current word.
- `Selector`  out  2  index of the granted source; drives the mux select.
- `Grant`  out  4  one-hot grant; all zeros when idle.
- `Valid`  out  1  the mux output word is valid for downstream.
- `Last`  out  1  the current transfer is the final beat of the burst.

## Operation
- Two states: IDLE and GRANT. Registered state: `Selector`, `Grant`, the beat counter, and the last-winner pointer `Last_Winner[1:0]`.
- Arbitration function:
  - Search order is `Last_Winner+1`, `+2`, `+3`, `+4` (mod 4).
  - The first asserted `Request` bit wins.
  - The previous winner has the lowest priority but can win again if it is the only requester.
- IDLE:
  - If `Request` != 0: load `Selector` = winner and `Grant` = one-hot(winner), clear the beat counter, go to GRANT.
  - Otherwise stay in IDLE with `Grant` = 0.
- GRANT:
  - `Valid` = `Request[Selector]`, combinational from the registered `Selector`.
  - A transfer occurs when `Valid && Ready`.
  - `Last` = `Valid` && (counter == `BURST_LENGTH`-1).
- GRANT transitions:
  - Transfer with `Last` = 1: set `Last_Winner` = `Selector`. Re-arbitrate in the same cycle on the current `Request`, using the updated pointer.
    - If any request exists, load the new winner, clear the counter, stay in GRANT. There is no bubble between bursts.
    - Otherwise go to IDLE.
  - Transfer with `Last` = 0: increment the counter and keep the same grant.
  - `Request[Selector]` = 0 (abort): set `Last_Winner` = `Selector` and go to IDLE. The counter is discarded; the aborted source loses its turn.
  - No transfer and the request is held: hold all state.
- `Selector` and `Grant` change only on a grant load or on the return to IDLE. They never change while `Valid` = 1 and `Ready` = 0.
- When returning to IDLE: `Grant` clears to 0 and `Selector` keeps its last value.

## Timing
- Reset (`reset` = 0 at a clock edge):
  - state IDLE, `Selector` = 0, `Grant` = 0, counter = 0, `Last_Winner` = 3.
  - `Valid` = 0 and `Last` = 0 while in IDLE.
- Reset asserted mid-burst forces all of the above on that edge. In-flight beats are dropped and nothing is held over.
- Latency:
  - First `Valid` appears 1 cycle after `Request` rises from IDLE.
  - Minimum burst is `BURST_LENGTH` cycles with `Ready` held high.
  - Back-to-back bursts run with 0 idle cycles.
- Throughput is 1 word per cycle when `Ready` = 1.
- `Valid` and `Last` are combinational from `Request` plus state. Sources must not drop `Request` speculatively.
- Counter arithmetic is unsigned, `COUNT_WIDTH` bits, and never exceeds `BURST_LENGTH`-1. With `BURST_LENGTH` = 1, `Last` = `Valid` in GRANT.
- If Request and transfer happen on the same edge, the transfer decision uses the `Request` value at that edge.

## Test plan
- **Reset and first grant:** Release reset, then at cycle 2 drive `Request` = 4'b0101 and `Ready` = 1 (`BURST_LENGTH` = 1). Required: cycle 3 `Selector` = 0, `Grant` = 0001, `Valid` = 1, `Last` = 1; cycle 4 `Selector` = 2, `Grant` = 0100; cycle 5 `Selector` = 0.
- **Fairness:** Hold `Request` = 4'b1111, `Ready` = 1, `BURST_LENGTH` = 2. Required: `Selector` sequence 0,0,1,1,2,2,3,3,0 with `Last` high on every second beat and no gaps in `Valid`.
- **Backpressure:** `BURST_LENGTH` = 4, single requester 1, `Ready` toggling 1,0,0,1,1,1. Required: `Selector` = 1 throughout; exactly 4 transfers; `Last` only with the 4th accepted beat; counter holds while `Ready` = 0.
- **Abort:** Requester 3 drops `Request` after 1 of 4 beats while 0 and 2 are also requesting. Required: `Valid` = 0 that cycle, IDLE next cycle, then a grant to source 0 (pointer = 3).
- **Reset mid-burst:** Assert `reset` = 0 during beat 2 of source 2. Required on the next edge: `Grant` = 0, `Selector` = 0, `Valid` = 0; after release, source 0 wins before source 2 given `Request` = 4'b0101.
- **Sole requester re-win:** Only source 2 requesting continuously, `BURST_LENGTH` = 1. Required: `Grant` = 0100 every cycle and `Valid` held high with no bubbles.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the 4:1 word-mux select: grants one source for a burst of BURST_LENGTH beats, then rotates.
// Valid/Last are combinational from Request and registered state; grant is held stable under downstream backpressure.
module mux4_rr_arbiter #(
    parameter int BURST_LENGTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Request,
    input  logic       Ready,
    output logic [1:0] Selector,
    output logic [3:0] Grant,
    output logic       Valid,
    output logic       Last
);

    localparam int COUNT_WIDTH = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_BEAT = COUNT_WIDTH'(BURST_LENGTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [1:0]             sel_nxt;
    logic [3:0]             grant_nxt;
    logic [1:0]             last_winner, last_winner_nxt;
    logic [COUNT_WIDTH-1:0] beat_cnt, beat_cnt_nxt;
    logic [2:0]             pick_idle, pick_rot;

    // Returns {found, index}; the loop runs lowest priority first so the nearest
    // requester after ptr overwrites the others.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign pick_idle = rr_pick(Request, last_winner);
    // At the end of a burst the pointer becomes Selector, so search from it directly.
    assign pick_rot  = rr_pick(Request, Selector);

    always_comb begin
        state_nxt       = state;
        sel_nxt         = Selector;
        grant_nxt       = Grant;
        last_winner_nxt = last_winner;
        beat_cnt_nxt    = beat_cnt;
        Valid           = 1'b0;
        Last            = 1'b0;
        case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_nxt    = GRANT;
                    sel_nxt      = pick_idle[1:0];
                    grant_nxt    = 4'b0001 << pick_idle[1:0];
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                Valid = Request[Selector];
                Last  = Valid && (beat_cnt == LAST_BEAT);
                if (!Valid) begin
                    // Abort: the source forfeits the rest of its turn.
                    last_winner_nxt = Selector;
                    state_nxt       = IDLE;
                    grant_nxt       = 4'b0000;
                    beat_cnt_nxt    = '0;
                end else if (Ready) begin
                    if (Last) begin
                        last_winner_nxt = Selector;
                        beat_cnt_nxt    = '0;
                        if (pick_rot[2]) begin
                            sel_nxt   = pick_rot[1:0];
                            grant_nxt = 4'b0001 << pick_rot[1:0];
                        end else begin
                            state_nxt = IDLE;
                            grant_nxt = 4'b0000;
                        end
                    end else begin
                        beat_cnt_nxt = beat_cnt + COUNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            Selector    <= 2'd0;
            Grant       <= 4'b0000;
            beat_cnt    <= '0;
            last_winner <= 2'd3;
        end else begin
            state       <= state_nxt;
            Selector    <= sel_nxt;
            Grant       <= grant_nxt;
            beat_cnt    <= beat_cnt_nxt;
            last_winner <= last_winner_nxt;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Three arbiters (BURST_LENGTH 1, 2, 4) checked every cycle against a behavioural model plus directed literals.
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i  [3];
    logic [3:0] req_i  [3];
    logic       rdy_i  [3];
    logic [1:0] sel_o  [3];
    logic [3:0] gnt_o  [3];
    logic       vld_o  [3];
    logic       last_o [3];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mux4_rr_arbiter #(.BURST_LENGTH(g == 0 ? 1 : (g == 1 ? 2 : 4))) dut (
            .clk      (clk),
            .reset    (rst_i[g]),
            .Request  (req_i[g]),
            .Ready    (rdy_i[g]),
            .Selector (sel_o[g]),
            .Grant    (gnt_o[g]),
            .Valid    (vld_o[g]),
            .Last     (last_o[g])
        );
    end

    function automatic int bl_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    // First requester found walking forward from the pointer; -1 when none.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic check(input string nm, input int g, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t: got %0d, expected %0d", nm, g, $time, got, exp);
        end
    endtask

    // Model: owner of the mux (or none), beats remaining in its burst, rotation pointer.
    bit m_init [3];
    bit m_busy [3];
    int m_sel  [3];
    int m_left [3];
    int m_ptr  [3];
    int w;

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_i[g]) begin
                m_init[g] = 1'b1;
                m_busy[g] = 1'b0;
                m_sel[g]  = 0;
                m_left[g] = 0;
                m_ptr[g]  = 3;
            end else if (m_init[g]) begin
                if (!m_busy[g]) begin
                    w = pick(req_i[g], m_ptr[g]);
                    if (w >= 0) begin
                        m_busy[g] = 1'b1;
                        m_sel[g]  = w;
                        m_left[g] = bl_of(g);
                    end
                end else if (!req_i[g][m_sel[g]]) begin
                    m_ptr[g]  = m_sel[g];
                    m_busy[g] = 1'b0;
                end else if (rdy_i[g]) begin
                    m_left[g] = m_left[g] - 1;
                    if (m_left[g] == 0) begin
                        m_ptr[g] = m_sel[g];
                        w = pick(req_i[g], m_ptr[g]);
                        if (w >= 0) begin
                            m_sel[g]  = w;
                            m_left[g] = bl_of(g);
                        end else begin
                            m_busy[g] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (m_init[g]) begin
                int ev;
                ev = (m_busy[g] && req_i[g][m_sel[g]]) ? 1 : 0;
                check("model_selector", g, int'(sel_o[g]), m_sel[g]);
                check("model_grant",    g, int'(gnt_o[g]), m_busy[g] ? (1 << m_sel[g]) : 0);
                check("model_valid",    g, int'(vld_o[g]), ev);
                check("model_last",     g, int'(last_o[g]), (ev == 1 && m_left[g] == 1) ? 1 : 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int fair_sel [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int bp_rdy   [6] = '{1, 0, 0, 1, 1, 1};
    int bp_last  [6] = '{0, 0, 0, 0, 0, 1};
    int xfers;

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst_i[g] = 1'b0;
            req_i[g] = 4'b0000;
            rdy_i[g] = 1'b0;
        end
        tick();
        req_i[0] = 4'b0101;
        tick();
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("reset_grant",    g, int'(gnt_o[g]), 0);
            check("reset_selector", g, int'(sel_o[g]), 0);
            check("reset_valid",    g, int'(vld_o[g]), 0);
        end
        for (int g = 0; g < 3; g++) rst_i[g] = 1'b1;
        req_i[0] = 4'b0000;
        tick();

        // Reset and first grant, BURST_LENGTH 1
        req_i[0] = 4'b0101;
        rdy_i[0] = 1'b1;
        tick();
        @(negedge clk);
        check("first_selector", 0, int'(sel_o[0]), 0);
        check("first_grant",    0, int'(gnt_o[0]), 1);
        check("first_valid",    0, int'(vld_o[0]), 1);
        check("first_last",     0, int'(last_o[0]), 1);
        tick();
        @(negedge clk);
        check("second_selector", 0, int'(sel_o[0]), 2);
        check("second_grant",    0, int'(gnt_o[0]), 4);
        tick();
        @(negedge clk);
        check("third_selector", 0, int'(sel_o[0]), 0);
        req_i[0] = 4'b0000;
        tick();
        tick();

        // Sole requester re-wins with no bubbles
        req_i[0] = 4'b0100;
        tick();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("solo_grant", 0, int'(gnt_o[0]), 4);
            check("solo_valid", 0, int'(vld_o[0]), 1);
            tick();
        end
        req_i[0] = 4'b0000;
        tick();

        // Fairness, BURST_LENGTH 2
        req_i[1] = 4'b1111;
        rdy_i[1] = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("fair_selector", 1, int'(sel_o[1]), fair_sel[i]);
            check("fair_last",     1, int'(last_o[1]), i % 2);
            check("fair_valid",    1, int'(vld_o[1]), 1);
            tick();
        end
        req_i[1] = 4'b0000;
        tick();

        // Backpressure, BURST_LENGTH 4
        req_i[2] = 4'b0010;
        rdy_i[2] = 1'b0;
        tick();
        xfers = 0;
        for (int i = 0; i < 6; i++) begin
            rdy_i[2] = bp_rdy[i][0];
            @(negedge clk);
            check("bp_selector", 2, int'(sel_o[2]), 1);
            check("bp_last",     2, int'(last_o[2]), bp_last[i]);
            if (vld_o[2] && rdy_i[2]) xfers++;
            tick();
        end
        check("bp_transfers", 2, xfers, 4);
        req_i[2] = 4'b0000;
        tick();
        tick();

        // Abort: source 3 drops after one beat while 0 and 2 request
        req_i[2] = 4'b1000;
        rdy_i[2] = 1'b1;
        tick();
        req_i[2] = 4'b1101;
        @(negedge clk);
        check("abort_pre_selector", 2, int'(sel_o[2]), 3);
        check("abort_pre_valid",    2, int'(vld_o[2]), 1);
        tick();
        req_i[2] = 4'b0101;
        @(negedge clk);
        check("abort_valid", 2, int'(vld_o[2]), 0);
        tick();
        @(negedge clk);
        check("abort_idle_grant", 2, int'(gnt_o[2]), 0);
        check("abort_idle_valid", 2, int'(vld_o[2]), 0);
        tick();
        @(negedge clk);
        check("abort_next_selector", 2, int'(sel_o[2]), 0);
        check("abort_next_grant",    2, int'(gnt_o[2]), 1);

        // Reset during beat 2 of source 2
        rst_i[2] = 1'b0;
        tick();
        rst_i[2] = 1'b1;
        req_i[2] = 4'b0100;
        tick();
        tick();
        rst_i[2] = 1'b0;
        @(negedge clk);
        check("midrst_beat2_valid", 2, int'(vld_o[2]), 1);
        check("midrst_beat2_sel",   2, int'(sel_o[2]), 2);
        tick();
        @(negedge clk);
        check("midrst_grant",    2, int'(gnt_o[2]), 0);
        check("midrst_selector", 2, int'(sel_o[2]), 0);
        check("midrst_valid",    2, int'(vld_o[2]), 0);
        rst_i[2] = 1'b1;
        req_i[2] = 4'b0101;
        tick();
        @(negedge clk);
        check("postrst_selector", 2, int'(sel_o[2]), 0);
        check("postrst_grant",    2, int'(gnt_o[2]), 1);

        for (int g = 0; g < 3; g++) req_i[g] = 4'b0000;
        tick();
        tick();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
